// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants and types for the two-digit 7-segment scan driver.
//   - SEG_OFF / ZERO_GLYPH / AN_OFF : blanked segment bus, the "0" glyph and
//     the all-anodes-off vector (sliced to NUM_AN by the user)
//   - SEG_A..SEG_G                  : bit positions inside a {g,f,e,d,c,b,a}
//                                     pattern
//   - slot_idx_e / slot_pos_t       : which digit is being scanned, plus the
//                                     cycle count within that slot
//   - pack_digit()                  : gathers one digit's segments from the
//                                     per-segment [1:0] input lines
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [6:0] ZERO_GLYPH = 7'b0111111;

    // Wide enough for any practical board; the top slices it to NUM_AN.
    localparam int                MAX_AN = 32;
    localparam logic [MAX_AN-1:0] AN_OFF = '1;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Slot counter is carried zero-extended at this width, so REFRESH_DIV
    // up to 2**32 is representable.
    localparam int SLOT_CNT_W = 32;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_idx_e;

    typedef struct packed {
        slot_idx_e             idx;
        logic [SLOT_CNT_W-1:0] cnt;
    } slot_pos_t;

    // Selects bit 'sel' of every segment line: sel=0 -> ones, sel=1 -> tens.
    function automatic logic [6:0] pack_digit(
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c,
        input logic [1:0] d,
        input logic [1:0] e,
        input logic [1:0] f,
        input logic [1:0] g,
        input logic       sel
    );
        logic [6:0] p;
        p        = '0;
        p[SEG_A] = a[sel];
        p[SEG_B] = b[sel];
        p[SEG_C] = c[sel];
        p[SEG_D] = d[sel];
        p[SEG_E] = e[sel];
        p[SEG_F] = f[sel];
        p[SEG_G] = g[sel];
        return p;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Bundles the adder-stage inputs and the board display outputs of the scan
//   driver.
//   - en, A..G[1:0], DP : from the adder stage ([0]=ones, [1]=tens,
//                         active-high segments, DP=1 means negative)
//   - seg_n, dp_n, an_n : shared active-low segment bus, decimal point and
//                         per-digit anode enables
//   - frame_tick        : one-cycle pulse on the first cycle of each frame
//   Modports: master = adder/board side, slave = the scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_AN = 4
);
    logic              en;
    logic [1:0]        A;
    logic [1:0]        B;
    logic [1:0]        C;
    logic [1:0]        D;
    logic [1:0]        E;
    logic [1:0]        F;
    logic [1:0]        G;
    logic              DP;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [NUM_AN-1:0] an_n;
    logic              frame_tick;

    modport master (
        output en, A, B, C, D, E, F, G, DP,
        input  seg_n, dp_n, an_n, frame_tick
    );

    modport slave (
        input  en, A, B, C, D, E, F, G, DP,
        output seg_n, dp_n, an_n, frame_tick
    );
endinterface

// File: rtl/seg7_slot_timer.sv
// -----------------------------------------------------------------------------
// seg7_slot_timer
//   Slot position counter for the scan driver. cnt runs 0..REFRESH_DIV-1;
//   each wrap toggles idx between the ones and tens slot, so a frame is two
//   slots.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     pos_next    : position the counter will hold after this edge
//     frame_wrap  : high in the cycle whose edge ends the tens slot, i.e.
//                   the edge on which the next frame begins
// -----------------------------------------------------------------------------
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic      clk,
    input  logic      rst_n,
    output slot_pos_t pos_next,
    output logic      frame_wrap
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    slot_idx_e        idx_q;
    slot_idx_e        idx_d;
    logic             wrap;

    always_comb begin
        wrap       = (cnt_q == CNT_LAST);
        cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (wrap) begin
            idx_d = (idx_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end
        frame_wrap = wrap && (idx_q == SLOT_TENS);

        pos_next.idx = idx_d;
        pos_next.cnt = SLOT_CNT_W'(cnt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= SLOT_ONES;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Multiplexes the two-digit signed-adder display onto one shared segment bus
//   with per-digit anode enables. Inputs are snapshotted once per frame, so a
//   digit pair never tears mid-scan. Optional tens-digit leading-zero blanking
//   keeps the anode on when the sign must still be shown.
//   Parameters:
//     REFRESH_DIV : clk cycles per digit slot (>= 4)
//     GUARD       : cycles at slot start with all anodes off (1..REFRESH_DIV-2)
//     NUM_AN      : physical anodes; anodes 2..NUM_AN-1 stay off
//     BLANK_TENS  : 1 = blank a tens digit showing the "0" glyph
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : slave side of seg7_scan_driver_if (en, A..G, DP in;
//                  seg_n, dp_n, an_n, frame_tick out)
//   Every output is a flop loaded from the next-state position/shadow, so the
//   value seen in a cycle matches that cycle's slot position and snapshot.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int NUM_AN      = 4,
    parameter int BLANK_TENS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    bus
);

    slot_pos_t pos_d;
    logic      frame_wrap;

    seg7_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .pos_next   (pos_d),
        .frame_wrap (frame_wrap)
    );

    // ---------------------------------------------------------------------
    // Frame snapshot: digit patterns in {g..a} order, [0]=ones, [1]=tens.
    // ---------------------------------------------------------------------
    logic [1:0][6:0] live_digit;
    logic [1:0][6:0] digit_q;
    logic [1:0][6:0] digit_d;
    logic            sign_q;
    logic            sign_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_live
        assign live_digit[gi] = pack_digit(bus.A, bus.B, bus.C, bus.D,
                                           bus.E, bus.F, bus.G, 1'(gi));
    end

    // The capture edge takes whatever is on the inputs at that edge.
    always_comb begin
        digit_d = digit_q;
        sign_d  = sign_q;
        if (frame_wrap) begin
            digit_d = live_digit;
            sign_d  = bus.DP;
        end
    end

    // ---------------------------------------------------------------------
    // Output decode on the next position / next snapshot.
    // ---------------------------------------------------------------------
    logic              idx_bit;
    logic              active;
    logic [6:0]        pat;
    logic              tens_zero;
    logic              lit;
    logic [6:0]        seg_d;
    logic              dp_n_d;
    logic [NUM_AN-1:0] an_d;
    logic              tick_d;

    always_comb begin
        idx_bit   = (pos_d.idx == SLOT_TENS);
        active    = bus.en && (pos_d.cnt >= SLOT_CNT_W'(GUARD));
        pat       = digit_d[idx_bit];
        tens_zero = (BLANK_TENS != 0) && idx_bit && (pat == ZERO_GLYPH);
        tick_d    = frame_wrap;

        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        lit    = 1'b0;

        if (active) begin
            if (idx_bit) begin
                dp_n_d = ~sign_d;
            end
            if (tens_zero) begin
                // Leading zero: keep the anode only to show a minus sign,
                // with the segments dark.
                lit = sign_d;
            end else begin
                lit   = 1'b1;
                seg_d = ~pat;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_AN; gi++) begin : g_an
        if (gi < 2) begin : g_digit
            assign an_d[gi] = ~(lit && (idx_bit == 1'(gi)));
        end else begin : g_spare
            assign an_d[gi] = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers.
    // ---------------------------------------------------------------------
    logic [6:0]        seg_q;
    logic              dp_n_q;
    logic [NUM_AN-1:0] an_q;
    logic              tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            sign_q  <= 1'b0;
            seg_q   <= SEG_OFF;
            dp_n_q  <= 1'b1;
            an_q    <= AN_OFF[NUM_AN-1:0];
            tick_q  <= 1'b0;
        end else begin
            digit_q <= digit_d;
            sign_q  <= sign_d;
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed plus randomized stimulus for seg7_scan_driver with
//   REFRESH_DIV=8, GUARD=1, NUM_AN=4, BLANK_TENS=1. The reference model
//   derives the slot position from the elapsed cycle count t since reset
//   release (cnt = t mod 8, slot = (t / 8) mod 2) and keeps the frame
//   snapshot as whole digit patterns.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int GD = 1;
    localparam int NA = 4;
    localparam logic [6:0] ZERO = 7'b0111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_driver_if #(.NUM_AN(NA)) bus ();

    seg7_scan_driver #(
        .REFRESH_DIV (RD),
        .GUARD       (GD),
        .NUM_AN      (NA),
        .BLANK_TENS  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state
    int         t;
    logic [6:0] in_ones, in_tens;
    logic       in_dp;
    logic [6:0] sh_ones, sh_tens;
    logic       sh_dp;
    logic       en_cap;

    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_tick;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
        end
    endtask

    task automatic drive_sum(input logic [6:0] tens, input logic [6:0] ones, input logic dp);
        in_tens = tens;
        in_ones = ones;
        in_dp   = dp;
        bus.A   = {tens[0], ones[0]};
        bus.B   = {tens[1], ones[1]};
        bus.C   = {tens[2], ones[2]};
        bus.D   = {tens[3], ones[3]};
        bus.E   = {tens[4], ones[4]};
        bus.F   = {tens[5], ones[5]};
        bus.G   = {tens[6], ones[6]};
        bus.DP  = dp;
    endtask

    task automatic model_outputs();
        int cnt;
        int slot;
        cnt      = t % RD;
        slot     = (t / RD) % 2;
        exp_an   = 4'hF;
        exp_seg  = 7'h7F;
        exp_dp   = 1'b1;
        exp_tick = (t > 0) && (t % (2 * RD) == 0);
        if (en_cap && cnt >= GD) begin
            if (slot == 0) begin
                exp_an  = 4'b1110;
                exp_seg = ~sh_ones;
            end else begin
                exp_dp = ~sh_dp;
                if (sh_tens == ZERO) begin
                    if (sh_dp) exp_an = 4'b1101;
                end else begin
                    exp_an  = 4'b1101;
                    exp_seg = ~sh_tens;
                end
            end
        end
    endtask

    task automatic check_all();
        model_outputs();
        chk("an_n",       {4'b0, bus.an_n},       {4'b0, exp_an});
        chk("seg_n",      {1'b0, bus.seg_n},      {1'b0, exp_seg});
        chk("dp_n",       {7'b0, bus.dp_n},       {7'b0, exp_dp});
        chk("frame_tick", {7'b0, bus.frame_tick}, {7'b0, exp_tick});
    endtask

    // One clock: the model captures what the DUT sees at this edge, then the
    // outputs are compared 1 time unit after the edge.
    task automatic cycle();
        if (t % (2 * RD) == 2 * RD - 1) begin
            sh_ones = in_ones;
            sh_tens = in_tens;
            sh_dp   = in_dp;
        end
        en_cap = bus.en;
        t++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_phase(input int period, input int phase);
        for (int i = 0; i < 2 * RD && (t % period) != phase; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_an_n",  {4'b0, bus.an_n},       8'h0F);
        chk("reset_seg_n", {1'b0, bus.seg_n},      8'h7F);
        chk("reset_dp_n",  {7'b0, bus.dp_n},       8'h01);
        chk("reset_tick",  {7'b0, bus.frame_tick}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        t       = 0;
        sh_ones = '0;
        sh_tens = '0;
        sh_dp   = 1'b0;
        en_cap  = bus.en;
        check_all();
    endtask

    initial begin
        logic [6:0] r_tens, r_ones;
        t      = 0;
        bus.en = 1'b1;
        drive_sum(7'd0, 7'd0, 1'b0);
        @(posedge clk);
        #1;

        // 1. Reset, then first frame with zero snapshot; +7 waits on the inputs.
        do_reset();
        drive_sum(ZERO, 7'b0000111, 1'b0);
        $display("[TB] step 1/2: reset and +7");
        run(48);

        // 3. -25
        drive_sum(7'b1011011, 7'b1101101, 1'b1);
        $display("[TB] step 3: -25");
        run(40);

        // 4. -3 : tens zero with sign, anode stays on, segments dark
        drive_sum(ZERO, 7'b1001111, 1'b1);
        $display("[TB] step 4: -3");
        run(40);

        // 5. Change inputs at cnt=3 in the ones slot
        run_to_phase(2 * RD, 3);
        drive_sum(7'b0000110, 7'b1111111, 1'b0);
        $display("[TB] step 5: mid-frame input change at t=%0d", t);
        run(24);

        // 6. Drop en for 5 cycles mid-slot
        run_to_phase(2 * RD, 10);
        bus.en = 1'b0;
        $display("[TB] step 6: en low at t=%0d", t);
        run(5);
        bus.en = 1'b1;
        run(20);

        // Async reset mid-slot while a digit is lit
        run_to_phase(RD, 4);
        $display("[TB] step 6: async reset at t=%0d", t);
        do_reset();
        drive_sum(7'b1011011, 7'b1101101, 1'b1);
        run(36);

        // Randomized traffic, including changes on capture edges and en toggles
        for (int i = 0; i < 320; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                r_tens = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
                r_ones = 7'($urandom);
                drive_sum(r_tens, r_ones, 1'($urandom));
                $display("[TB] rand t=%0d tens=%b ones=%b dp=%0b", t, r_tens, r_ones, in_dp);
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.en = ~bus.en;
                $display("[TB] rand t=%0d en=%0b", t, bus.en);
            end
            cycle();
        end
        bus.en = 1'b1;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
